// File: rtl/deadlock_monitor_pkg.sv
// ============================================================================
// Module : deadlock_monitor_pkg
// Brief  : Shared state encoding and constants for the AXIS stall monitor.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package deadlock_monitor_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SUSPECT  = 2'd1,
    DEADLOCK = 2'd2
  } monitor_state_e;

  localparam int C_DEFAULT_THRESH = 1024;

  // Channel k is owned by the instance whose idle flag sits at bit k+1.
  localparam int C_IDLE_IDX_OFFSET = 1;

endpackage

`default_nettype wire

// File: rtl/stall_vector_qualifier.sv
// ============================================================================
// Module : stall_vector_qualifier
// Brief  : Idle-gates the channel block vector, registers it once and flags
//          progress when a previously stalled channel releases.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module stall_vector_qualifier
  import deadlock_monitor_pkg::*;
#(
  parameter int N_AXIS     = 3,
  parameter int N_INST_BLK = 1
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic [N_AXIS-1:0]     axis_block_sigs,
  input  logic [N_AXIS:0]       inst_idle_sigs,
  input  logic [N_INST_BLK-1:0] inst_block_sigs,
  output logic [N_AXIS-1:0]     stall_q,
  output logic                  inst_q,
  output logic                  active,
  output logic                  progress
);

  logic [N_AXIS-1:0] w_stall_raw;
  logic [N_AXIS-1:0] r_stall_q;
  logic [N_AXIS-1:0] r_stall_prev;
  logic              r_inst_q;
  logic              w_unused_top_idle;

  assign w_unused_top_idle = inst_idle_sigs[0];

  generate
    for (genvar k = 0; k < N_AXIS; k++) begin : g_idle_gate
      assign w_stall_raw[k] = axis_block_sigs[k] & ~inst_idle_sigs[k + C_IDLE_IDX_OFFSET];
    end
  endgenerate

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_stall_q    <= '0;
      r_stall_prev <= '0;
      r_inst_q     <= 1'b0;
    end else begin
      r_stall_q    <= w_stall_raw;
      r_stall_prev <= r_stall_q;
      r_inst_q     <= |inst_block_sigs;
    end
  end

  assign stall_q  = r_stall_q;
  assign inst_q   = r_inst_q;
  assign active   = (|r_stall_q) | r_inst_q;
  // Only a release counts; channels joining the stall set are not progress.
  assign progress = |(r_stall_prev & ~r_stall_q);

endmodule

`default_nettype wire

// File: rtl/axis_stall_persistence_monitor.sv
// ============================================================================
// Module : axis_stall_persistence_monitor
// Brief  : Declares a sticky deadlock once a no-progress stall persists for
//          THRESH cycles, freezing the contributing channel snapshot.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module axis_stall_persistence_monitor
  import deadlock_monitor_pkg::*;
#(
  parameter int N_AXIS     = 3,
  parameter int N_INST_BLK = 1,
  parameter int THRESH     = C_DEFAULT_THRESH,
  parameter int CNT_W      = 16
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic [N_AXIS-1:0]     axis_block_sigs,
  input  logic [N_AXIS:0]       inst_idle_sigs,
  input  logic [N_INST_BLK-1:0] inst_block_sigs,
  input  logic                  clear,
  output logic                  block,
  output logic [N_AXIS-1:0]     block_mask,
  output logic                  inst_block_hit,
  output logic [CNT_W-1:0]      stall_cnt,
  output logic                  suspect
);

  localparam logic [CNT_W-1:0] C_CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(THRESH - 1);
  localparam logic [CNT_W-1:0] C_CNT_FULL = CNT_W'(THRESH);

  logic [N_AXIS-1:0] w_stall_q;
  logic              w_inst_q;
  logic              w_active;
  logic              w_progress;

  monitor_state_e    r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_block;
  logic [N_AXIS-1:0] r_block_mask;
  logic              r_inst_block_hit;

  stall_vector_qualifier #(
    .N_AXIS     (N_AXIS),
    .N_INST_BLK (N_INST_BLK)
  ) u_qualifier (
    .clock           (clock),
    .reset_n         (reset_n),
    .axis_block_sigs (axis_block_sigs),
    .inst_idle_sigs  (inst_idle_sigs),
    .inst_block_sigs (inst_block_sigs),
    .stall_q         (w_stall_q),
    .inst_q          (w_inst_q),
    .active          (w_active),
    .progress        (w_progress)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state          <= IDLE;
      r_cnt            <= '0;
      r_block          <= 1'b0;
      r_block_mask     <= '0;
      r_inst_block_hit <= 1'b0;
    end else if (clear) begin
      // Re-arm takes priority over any detection landing on the same edge.
      r_state          <= IDLE;
      r_cnt            <= '0;
      r_block          <= 1'b0;
      r_block_mask     <= '0;
      r_inst_block_hit <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_active) begin
            r_state <= SUSPECT;
            r_cnt   <= C_CNT_ONE;
          end
        end
        SUSPECT: begin
          if (!w_active) begin
            r_state <= IDLE;
            r_cnt   <= '0;
          end else if (w_progress) begin
            r_cnt <= C_CNT_ONE;
          end else if (r_cnt == C_CNT_LAST) begin
            r_state          <= DEADLOCK;
            r_cnt            <= C_CNT_FULL;
            r_block          <= 1'b1;
            r_block_mask     <= w_stall_q;
            r_inst_block_hit <= w_inst_q;
          end else begin
            r_cnt <= r_cnt + C_CNT_ONE;
          end
        end
        DEADLOCK: begin
          r_state <= DEADLOCK;
        end
        default: begin
          r_state <= IDLE;
          r_cnt   <= '0;
        end
      endcase
    end
  end

  assign block          = r_block;
  assign block_mask     = r_block_mask;
  assign inst_block_hit = r_inst_block_hit;
  assign stall_cnt      = r_cnt;
  assign suspect        = (r_state == SUSPECT);

endmodule

`default_nettype wire

// File: tb/tb_axis_stall_persistence_monitor.sv
// ============================================================================
// Module : tb_axis_stall_persistence_monitor
// Brief  : Directed and randomized checks of the stall persistence monitor
//          against a cycle-level reference model.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_axis_stall_persistence_monitor;

  localparam int N_AXIS     = 3;
  localparam int N_INST_BLK = 1;
  localparam int THRESH     = 8;
  localparam int CNT_W      = 16;

  logic                  kernel_monitor_clock;
  logic                  reset_n;
  logic [N_AXIS-1:0]     axis_block_sigs;
  logic [N_AXIS:0]       inst_idle_sigs;
  logic [N_INST_BLK-1:0] inst_block_sigs;
  logic                  clear;
  logic                  block;
  logic [N_AXIS-1:0]     block_mask;
  logic                  inst_block_hit;
  logic [CNT_W-1:0]      stall_cnt;
  logic                  suspect;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: history of sampled stall vectors plus detector status.
  logic [N_AXIS-1:0] stall_hist[$];
  logic              inst_hist[$];
  int                m_cnt;
  bit                m_dead;
  logic [N_AXIS-1:0] m_mask;
  bit                m_hit;

  axis_stall_persistence_monitor #(
    .N_AXIS     (N_AXIS),
    .N_INST_BLK (N_INST_BLK),
    .THRESH     (THRESH),
    .CNT_W      (CNT_W)
  ) dut (
    .clock           (kernel_monitor_clock),
    .reset_n         (reset_n),
    .axis_block_sigs (axis_block_sigs),
    .inst_idle_sigs  (inst_idle_sigs),
    .inst_block_sigs (inst_block_sigs),
    .clear           (clear),
    .block           (block),
    .block_mask      (block_mask),
    .inst_block_hit  (inst_block_hit),
    .stall_cnt       (stall_cnt),
    .suspect         (suspect)
  );

  initial kernel_monitor_clock = 1'b0;
  always #5 kernel_monitor_clock = ~kernel_monitor_clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    stall_hist.delete();
    inst_hist.delete();
    stall_hist.push_back('0);
    stall_hist.push_back('0);
    inst_hist.push_back(1'b0);
    m_cnt  = 0;
    m_dead = 0;
    m_mask = '0;
    m_hit  = 0;
  endtask

  // One rising edge of the specification rules; cnt==0 outside DEADLOCK means idle.
  task automatic model_step(input logic [N_AXIS-1:0] a, input logic [N_AXIS:0] idl,
                            input logic [N_INST_BLK-1:0] b, input logic clr);
    logic [N_AXIS-1:0] sq, sqp, raw;
    logic iq;
    bit act, prog;
    sq   = stall_hist[stall_hist.size()-1];
    sqp  = stall_hist[stall_hist.size()-2];
    iq   = inst_hist[inst_hist.size()-1];
    act  = (sq != 0) || iq;
    prog = (sqp & ~sq) != 0;
    if (clr) begin
      m_dead = 0; m_cnt = 0; m_mask = '0; m_hit = 0;
    end else if (!m_dead) begin
      if (!act)                     m_cnt = 0;
      else if (m_cnt == 0)          m_cnt = 1;
      else if (prog)                m_cnt = 1;
      else if (m_cnt == THRESH - 1) begin
        m_dead = 1; m_cnt = THRESH; m_mask = sq; m_hit = iq;
      end else                      m_cnt = m_cnt + 1;
    end
    for (int k = 0; k < N_AXIS; k++) raw[k] = a[k] & ~idl[k+1];
    stall_hist.push_back(raw);
    void'(stall_hist.pop_front());
    inst_hist.push_back(|b);
    void'(inst_hist.pop_front());
  endtask

  task automatic compare_all(input string tag);
    check({tag, ".block"},   32'(block),          32'(m_dead));
    check({tag, ".mask"},    32'(block_mask),     32'(m_mask));
    check({tag, ".hit"},     32'(inst_block_hit), 32'(m_hit));
    check({tag, ".cnt"},     32'(stall_cnt),      32'(m_cnt));
    check({tag, ".suspect"}, 32'(suspect),        32'(!m_dead && m_cnt != 0));
  endtask

  // Entered and left at a falling edge.
  task automatic tick(input string tag, input logic [N_AXIS-1:0] a, input logic [N_AXIS:0] idl,
                      input logic [N_INST_BLK-1:0] b, input logic clr);
    axis_block_sigs = a;
    inst_idle_sigs  = idl;
    inst_block_sigs = b;
    clear           = clr;
    @(posedge kernel_monitor_clock);
    model_step(a, idl, b, clr);
    @(negedge kernel_monitor_clock);
    compare_all(tag);
  endtask

  task automatic check_zero(input string tag);
    check({tag, ".block"},   32'(block),          32'd0);
    check({tag, ".mask"},    32'(block_mask),     32'd0);
    check({tag, ".hit"},     32'(inst_block_hit), 32'd0);
    check({tag, ".cnt"},     32'(stall_cnt),      32'd0);
    check({tag, ".suspect"}, 32'(suspect),        32'd0);
  endtask

  task automatic do_reset();
    reset_n         = 1'b0;
    axis_block_sigs = '0;
    inst_idle_sigs  = '0;
    inst_block_sigs = '0;
    clear           = 1'b0;
    model_reset();
    @(negedge kernel_monitor_clock);
    @(negedge kernel_monitor_clock);
    check_zero("reset");
    reset_n = 1'b1;
  endtask

  task automatic run_scenario1(input string tag);
    for (int c = 0; c < THRESH; c++) tick(tag, 3'b001, 4'b0000, 1'b0, 1'b0);
    check({tag, ".pre_block"}, 32'(block), 32'd0);
    tick(tag, 3'b001, 4'b0000, 1'b0, 1'b0);
    check({tag, ".block"}, 32'(block),      32'd1);
    check({tag, ".mask"},  32'(block_mask), 32'b001);
    check({tag, ".cnt"},   32'(stall_cnt),  32'd8);
  endtask

  initial begin
    reset_n = 1'b0;
    do_reset();

    // Single channel stall held from cycle 0.
    run_scenario1("s1");

    // Blocked channel whose owner is idle never counts.
    do_reset();
    for (int c = 0; c < 20; c++) tick("s2", 3'b010, 4'b0100, 1'b0, 1'b0);
    check("s2.block",   32'(block),   32'd0);
    check("s2.suspect", 32'(suspect), 32'd0);

    // Release of channel 0 restarts the count.
    do_reset();
    for (int c = 0; c < 6; c++) tick("s3", 3'b011, 4'b0000, 1'b0, 1'b0);
    tick("s3", 3'b010, 4'b0000, 1'b0, 1'b0);
    tick("s3", 3'b010, 4'b0000, 1'b0, 1'b0);
    check("s3.restart_cnt", 32'(stall_cnt), 32'd1);
    for (int c = 0; c < 6; c++) tick("s3", 3'b010, 4'b0000, 1'b0, 1'b0);
    check("s3.pre_block", 32'(block), 32'd0);
    tick("s3", 3'b010, 4'b0000, 1'b0, 1'b0);
    check("s3.block", 32'(block),      32'd1);
    check("s3.mask",  32'(block_mask), 32'b010);

    // A channel joining the stall set does not restart the count.
    do_reset();
    for (int c = 0; c < 5; c++) tick("s4", 3'b001, 4'b0000, 1'b0, 1'b0);
    for (int c = 0; c < 4; c++) tick("s4", 3'b101, 4'b0000, 1'b0, 1'b0);
    check("s4.block", 32'(block),      32'd1);
    check("s4.mask",  32'(block_mask), 32'b101);

    // Sticky deadlock, then clear and re-arm.
    for (int c = 0; c < 5; c++) tick("s5", 3'b000, 4'b0000, 1'b0, 1'b0);
    check("s5.sticky_block", 32'(block),      32'd1);
    check("s5.sticky_mask",  32'(block_mask), 32'b101);
    tick("s5", 3'b000, 4'b0000, 1'b0, 1'b1);
    check_zero("s5.clear");
    run_scenario1("s5.rearm");

    // Asynchronous reset while counting.
    do_reset();
    for (int c = 0; c < 6; c++) tick("s6", 3'b001, 4'b0000, 1'b0, 1'b0);
    check("s6.cnt5", 32'(stall_cnt), 32'd5);
    #2 reset_n = 1'b0;
    #1 check_zero("s6.async");
    model_reset();
    @(negedge kernel_monitor_clock);
    reset_n = 1'b1;
    run_scenario1("s6.after");

    // Randomized traffic, including instance-level blocks and clears.
    do_reset();
    begin
      logic [N_AXIS-1:0]     ra;
      logic [N_AXIS:0]       ri;
      logic [N_INST_BLK-1:0] rb;
      ra = '0; ri = '0; rb = '0;
      for (int c = 0; c < 3000; c++) begin
        if ($urandom_range(0, 5) == 0) begin
          ra = N_AXIS'($urandom_range(0, 7));
          ri = ($urandom_range(0, 3) == 0) ? (N_AXIS+1)'($urandom_range(0, 15)) : '0;
          rb = ($urandom_range(0, 7) == 0) ? 1'b1 : 1'b0;
        end
        tick("rand", ra, ri, rb, ($urandom_range(0, 59) == 0));
        if (c % 700 == 699) do_reset();
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
